// File: rtl/bus_resp_regbank.sv
// Peripheral-side responder for the ibex req/gnt/rvalid data bus, fronting a
// small register bank (CTRL, IEN, W1C ISR, ISS, scratch) with a level interrupt.
module bus_resp_regbank #(
   parameter int NREG   = 8,
   parameter int ADDR_W = 14,
   parameter int WAIT   = 0,
   parameter int NIRQ   = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              req,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              gnt,
   output logic              rvalid,
   output logic [31:0]       rdata,
   input  logic [NIRQ-1:0]   irq_set,
   output logic [31:0]       ctrl,
   output logic              Int
);

   localparam int WIW = ADDR_W - 2;
   localparam int NS  = (NREG > 4) ? NREG - 4 : 1;
   localparam int SW  = (NS > 1) ? $clog2(NS) : 1;
   localparam int NSA = 2 ** SW;
   localparam logic [3:0] WLAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAITST, GRANT, RESP} state_t;

   state_t            state;
   state_t            nstate;
   logic [3:0]        cnt;
   logic              lwe;
   logic [3:0]        lbe;
   logic [WIW-1:0]    widx;
   logic [31:0]       lwdata;
   logic [31:0]       creg;
   logic [NIRQ-1:0]   ien;
   logic [NIRQ-1:0]   isr;
   logic [31:0]       scratch [NSA];
   logic [31:0]       bmask;
   logic [31:0]       rdmux;
   logic [NIRQ-1:0]   isrset;
   logic [NIRQ-1:0]   isrclr;
   logic [SW-1:0]     sidx;
   logic              inscratch;
   logic              commit;
   logic              unusedbits;

   // The full word index is kept so that indices past the bank are rejected
   // instead of aliasing onto real registers.
   assign unusedbits = ^addr[1:0];

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (req) nstate = (WAIT > 0) ? WAITST : GRANT;
         WAITST:  if (cnt == WLAST) nstate = GRANT;
         GRANT:   nstate = RESP;
         RESP:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   assign gnt    = (state == GRANT);
   assign rvalid = (state == RESP);
   assign ctrl   = creg;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cnt    <= '0;
         lwe    <= 1'b0;
         lbe    <= '0;
         widx   <= '0;
         lwdata <= '0;
      end else begin
         if (state == WAITST) begin
            cnt <= cnt + 4'd1;
         end else begin
            cnt <= '0;
         end
         if (state == IDLE && req) begin
            lwe    <= we;
            lbe    <= be;
            widx   <= addr[ADDR_W-1:2];
            lwdata <= wdata;
         end
      end
   end

   assign bmask     = {{8{lbe[3]}}, {8{lbe[2]}}, {8{lbe[1]}}, {8{lbe[0]}}};
   assign sidx      = SW'(widx - WIW'(4));
   assign inscratch = (widx >= WIW'(4)) && (widx < WIW'(NREG));
   assign commit    = (state == GRANT) && lwe;

   always_comb begin
      rdmux  = '0;
      isrset = '0;
      isrclr = '0;
      if (widx == WIW'(0)) begin
         rdmux = creg;
      end else if (widx == WIW'(1)) begin
         rdmux = 32'(ien);
      end else if (widx == WIW'(2)) begin
         rdmux  = 32'(isr);
         isrclr = commit ? (lwdata[NIRQ-1:0] & bmask[NIRQ-1:0]) : '0;
      end else if (widx == WIW'(3)) begin
         isrset = commit ? (lwdata[NIRQ-1:0] & bmask[NIRQ-1:0]) : '0;
      end else if (inscratch) begin
         rdmux = scratch[sidx];
      end
   end

   // Any set source beats the W1C clear so a coincident hardware event is kept.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         creg <= '0;
         ien  <= '0;
         isr  <= '0;
         Int  <= 1'b0;
         for (int i = 0; i < NSA; i++) begin
            scratch[i] <= '0;
         end
      end else begin
         isr <= (isr & ~isrclr) | isrset | irq_set;
         Int <= |(isr & ien);
         if (commit && widx == WIW'(0)) begin
            creg <= (creg & ~bmask) | (lwdata & bmask);
         end
         if (commit && widx == WIW'(1)) begin
            ien <= (ien & ~bmask[NIRQ-1:0]) | (lwdata[NIRQ-1:0] & bmask[NIRQ-1:0]);
         end
         if (commit && inscratch) begin
            scratch[sidx] <= (scratch[sidx] & ~bmask) | (lwdata & bmask);
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rdata <= '0;
      end else if (state == GRANT && !lwe) begin
         rdata <= rdmux;
      end else begin
         rdata <= '0;
      end
   end

endmodule

// File: tb/tb_bus_resp_regbank.sv
// Self-checking bench: two responders (WAIT=0 and WAIT=3) driven with directed
// and random transactions against a word-level model of the register map.
module tb_bus_resp_regbank;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        req    [2];
   logic        we     [2];
   logic [3:0]  be     [2];
   logic [13:0] addr   [2];
   logic [31:0] wdata  [2];
   logic [7:0]  irqs   [2];
   logic        gnt    [2];
   logic        rvalid [2];
   logic [31:0] rdata  [2];
   logic [31:0] ctrl   [2];
   logic        Int    [2];

   logic [31:0] mword [2][8];
   logic [7:0]  misr  [2];
   int          errors = 0;
   int          checks = 0;

   always #5 Clk = ~Clk;

   bus_resp_regbank #(.NREG(8), .ADDR_W(14), .WAIT(0), .NIRQ(8)) dut0 (
      .Clk(Clk), .Rst(Rst), .req(req[0]), .we(we[0]), .be(be[0]), .addr(addr[0]),
      .wdata(wdata[0]), .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]),
      .irq_set(irqs[0]), .ctrl(ctrl[0]), .Int(Int[0])
   );

   bus_resp_regbank #(.NREG(8), .ADDR_W(14), .WAIT(3), .NIRQ(8)) dut3 (
      .Clk(Clk), .Rst(Rst), .req(req[1]), .we(we[1]), .be(be[1]), .addr(addr[1]),
      .wdata(wdata[1]), .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]),
      .irq_set(irqs[1]), .ctrl(ctrl[1]), .Int(Int[1])
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] byteMask(input logic [3:0] b);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) m[8*i +: 8] = 8'hFF;
      end
      return m;
   endfunction

   function automatic void modelReset();
      for (int d = 0; d < 2; d++) begin
         misr[d] = '0;
         for (int i = 0; i < 8; i++) mword[d][i] = '0;
      end
   endfunction

   function automatic logic [31:0] modelRead(input int d, input int idx);
      if (idx == 2) return {24'h0, misr[d]};
      if (idx == 3 || idx >= 8) return 32'h0;
      return mword[d][idx];
   endfunction

   function automatic logic modelInt(input int d);
      return |(mword[d][1][7:0] & misr[d]);
   endfunction

   function automatic void modelCommit(input int d, input logic w, input logic [3:0] b,
                                       input int idx, input logic [31:0] wd, input logic [7:0] irq);
      logic [31:0] m;
      logic [7:0]  clr;
      logic [7:0]  set;
      m   = byteMask(b);
      clr = '0;
      set = '0;
      if (w) begin
         if (idx == 0 || (idx >= 4 && idx < 8)) mword[d][idx] = (mword[d][idx] & ~m) | (wd & m);
         if (idx == 1) mword[d][1] = ((mword[d][1] & ~m) | (wd & m)) & 32'h0000_00FF;
         if (idx == 2) clr = wd[7:0] & m[7:0];
         if (idx == 3) set = wd[7:0] & m[7:0];
      end
      misr[d] = (misr[d] & ~clr) | set | irq;
   endfunction

   // One full transaction starting on a falling edge with the responder idle;
   // irq is presented on the same rising edge as the commit.
   task automatic applyStimulus(input int d, input logic w, input logic [3:0] b, input int idx,
                                input logic [31:0] wd, input logic [7:0] irq, input string tag);
      int          wt;
      logic [31:0] expRd;
      logic        expIntPre;
      wt        = (d == 0) ? 0 : 3;
      expRd     = modelRead(d, idx);
      expIntPre = modelInt(d);
      req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = 14'(idx * 4); wdata[d] = wd;
      @(negedge Clk);
      req[d] = 1'b0; we[d] = 1'($urandom); be[d] = 4'($urandom);
      addr[d] = 14'($urandom); wdata[d] = $urandom;
      for (int k = 1; k <= wt + 1; k++) begin
         if (k == wt + 1) irqs[d] = irq;
         checkOutput({tag, ".gnt"}, 32'(gnt[d]), 32'(k == wt + 1));
         checkOutput({tag, ".rvalidEarly"}, 32'(rvalid[d]), 32'h0);
         if (k != wt + 1) @(negedge Clk);
      end
      modelCommit(d, w, b, idx, wd, irq);
      @(negedge Clk);
      irqs[d] = '0;
      checkOutput({tag, ".rvalid"}, 32'(rvalid[d]), 32'h1);
      checkOutput({tag, ".gntOnce"}, 32'(gnt[d]), 32'h0);
      checkOutput({tag, ".intPre"}, 32'(Int[d]), 32'(expIntPre));
      if (!w) checkOutput({tag, ".rdata"}, rdata[d], expRd);
      @(negedge Clk);
      checkOutput({tag, ".rvalidOnce"}, 32'(rvalid[d]), 32'h0);
      checkOutput({tag, ".rdataClear"}, rdata[d], 32'h0);
      checkOutput({tag, ".intPost"}, 32'(Int[d]), 32'(modelInt(d)));
      checkOutput({tag, ".ctrl"}, ctrl[d], mword[d][0]);
   endtask

   task automatic pulseIrq(input int d, input logic [7:0] irq, input string tag);
      logic expPre;
      expPre  = modelInt(d);
      irqs[d] = irq;
      @(negedge Clk);
      irqs[d] = '0;
      misr[d] = misr[d] | irq;
      checkOutput({tag, ".intLag"}, 32'(Int[d]), 32'(expPre));
      @(negedge Clk);
      checkOutput({tag, ".int"}, 32'(Int[d]), 32'(modelInt(d)));
   endtask

   initial begin
      logic [3:0]  rb;
      logic [31:0] rw;
      logic [7:0]  ri;
      int          ridx;
      Rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; be[d] = '0; addr[d] = '0; wdata[d] = '0; irqs[d] = '0;
      end
      modelReset();
      @(negedge Clk);
      @(negedge Clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput("reset.gnt", 32'(gnt[d]), 32'h0);
         checkOutput("reset.rvalid", 32'(rvalid[d]), 32'h0);
         checkOutput("reset.rdata", rdata[d], 32'h0);
         checkOutput("reset.ctrl", ctrl[d], 32'h0);
         checkOutput("reset.int", 32'(Int[d]), 32'h0);
      end
      Rst = 1'b0;
      @(negedge Clk);

      $display("[TB] scratch write/read with no wait states");
      applyStimulus(0, 1'b1, 4'b1111, 4, 32'hA5A5_A5A5, 8'h00, "w0.scratch");
      applyStimulus(0, 1'b0, 4'b0000, 4, 32'h0, 8'h00, "r0.scratch");

      $display("[TB] partial CTRL write with three wait states");
      applyStimulus(1, 1'b1, 4'b0101, 0, 32'h1234_5678, 8'h00, "w3.ctrl");
      checkOutput("ctrlPartial", ctrl[1], 32'h0034_0078);

      $display("[TB] interrupt enable, event, clear");
      applyStimulus(1, 1'b1, 4'b1111, 1, 32'h0000_0011, 8'h00, "w3.ien");
      pulseIrq(1, 8'h10, "irq4");
      checkOutput("intAfterIrq", 32'(Int[1]), 32'h1);
      applyStimulus(1, 1'b1, 4'b1111, 2, 32'h0000_0010, 8'h00, "w1c.isr");
      checkOutput("intAfterClear", 32'(Int[1]), 32'h0);
      applyStimulus(1, 1'b0, 4'b0000, 2, 32'h0, 8'h00, "r.isr");

      $display("[TB] hardware set against same-cycle W1C");
      pulseIrq(1, 8'h01, "irq0");
      applyStimulus(1, 1'b1, 4'b1111, 2, 32'h0000_0001, 8'h01, "w1c.race");
      applyStimulus(1, 1'b0, 4'b0000, 2, 32'h0, 8'h00, "r.race");
      checkOutput("intRace", 32'(Int[1]), 32'h1);

      $display("[TB] out-of-range index and empty byte enables");
      applyStimulus(0, 1'b0, 4'b1111, 12, 32'h0, 8'h00, "r0.oob");
      applyStimulus(0, 1'b1, 4'b1111, 12, 32'hFFFF_FFFF, 8'h00, "w0.oob");
      applyStimulus(0, 1'b1, 4'b0000, 5, 32'hFFFF_FFFF, 8'h00, "w0.be0");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1'b0, 4'b0000, i, 32'h0, 8'h00, "r0.sweep");
      end

      $display("[TB] random transactions");
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 30; n++) begin
            ridx = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 9));
            rb   = 4'($urandom);
            rw   = $urandom;
            ri   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            applyStimulus(d, 1'($urandom), rb, ridx, rw, ri, "rand");
         end
      end

      $display("[TB] reset during wait states of a scratch write");
      req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 14'h14; wdata[1] = 32'hDEAD_BEEF;
      @(negedge Clk);
      req[1] = 1'b0;
      @(negedge Clk);
      Rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         checkOutput("abort.gnt", 32'(gnt[1]), 32'h0);
         checkOutput("abort.rvalid", 32'(rvalid[1]), 32'h0);
      end
      Rst = 1'b0;
      modelReset();
      @(negedge Clk);
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         checkOutput("abort.noGnt", 32'(gnt[1]), 32'h0);
      end
      applyStimulus(1, 1'b0, 4'b0000, 5, 32'h0, 8'h00, "r3.afterAbort");
      applyStimulus(1, 1'b1, 4'b1111, 6, 32'h0BAD_F00D, 8'h00, "w3.afterAbort");
      applyStimulus(1, 1'b0, 4'b0000, 6, 32'h0, 8'h00, "r3.afterAbort2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
